// File: rtl/adder_tree_sched_if.sv
// Port bundle between the block scheduler and its environment: job control,
// input block stream, adder-tree issue/result path and indexed result stream.
interface adder_tree_sched_if #(
  parameter int unsigned IDX_W = 16
);
  logic             start;
  logic [IDX_W-1:0] num_blocks;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [1151:0]    in_data;
  logic             at_issue;
  logic [1151:0]    at_data;
  logic [191:0]     at_sum;
  logic             out_valid;
  logic             out_ready;
  logic [191:0]     out_data;
  logic [IDX_W-1:0] out_idx;

  // Environment side: drives job control, blocks, sums and result back-pressure.
  modport master (
    output start, num_blocks, in_valid, in_data, at_sum, out_ready,
    input  busy, done, in_ready, at_issue, at_data, out_valid, out_data, out_idx
  );

  // Scheduler side.
  modport slave (
    input  start, num_blocks, in_valid, in_data, at_sum, out_ready,
    output busy, done, in_ready, at_issue, at_data, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/adder_tree_sched.sv
// Issues input blocks to a fixed-latency adder tree and collects the sums in a
// first-word-fall-through FIFO tagged with the block index. Issue is throttled
// by credits so that every result in flight is guaranteed a FIFO slot.
module adder_tree_sched #(
  parameter int unsigned DELAY_ADD  = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IDX_W      = 16
) (
  input logic               clk,
  input logic               rst,
  adder_tree_sched_if.slave bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough for fifo_cnt + inflight without overflow.
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 2;
  localparam int unsigned EW = 192 + IDX_W;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] issued_q, issued_d;
  logic             done_q, done_d;
  logic [DELAY_ADD-1:0] sr_vld_q;
  logic [IDX_W-1:0] sr_idx_q [DELAY_ADD];
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic             issue, push, pop, fifo_nonempty, credit_ok;

  // Credits come from registered counts only; a pop this cycle frees a slot next cycle.
  assign credit_ok     = (fifo_cnt_q + inflight_q) < CW'(FIFO_DEPTH);
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign push          = sr_vld_q[DELAY_ADD-1];
  assign pop           = fifo_nonempty && bus.out_ready;

  assign bus.in_ready  = (state_q == StRun) && (issued_q < count_q) && credit_ok;
  assign issue         = bus.in_valid && bus.in_ready;
  assign bus.at_issue  = issue;
  assign bus.at_data   = bus.in_data;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.out_valid = fifo_nonempty;
  // Head is masked while empty so stale memory never shows on the outputs.
  assign {bus.out_data, bus.out_idx} = fifo_nonempty ? mem_q[rptr_q] : '0;

  assign inflight_d = inflight_q + CW'(issue) - CW'(push);
  assign fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

  // Next-state logic for job control and the issue counter.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.num_blocks != '0) begin
            state_d  = StRun;
            count_d  = bus.num_blocks;
            issued_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) issued_d = issued_q + 1'b1;
        if (issued_q == count_q) state_d = StDrain;
      end
      StDrain: begin
        if ((inflight_d == '0) && (fifo_cnt_d == '0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, counters, pipeline valids and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      issued_q   <= '0;
      done_q     <= 1'b0;
      sr_vld_q   <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      sr_vld_q[0] <= issue;
      for (int i = 1; i < DELAY_ADD; i++) sr_vld_q[i] <= sr_vld_q[i-1];
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Index pipeline and FIFO storage; contents are qualified by the valids above.
  always_ff @(posedge clk) begin
    sr_idx_q[0] <= issued_q;
    for (int i = 1; i < DELAY_ADD; i++) sr_idx_q[i] <= sr_idx_q[i-1];
    if (push) mem_q[wptr_q] <= {bus.at_sum, sr_idx_q[DELAY_ADD-1]};
  end
endmodule

// File: tb/tb_adder_tree_sched.sv
// Bench for adder_tree_sched: two instances (FIFO depth 16 and 4) share job
// control and back-pressure; each has its own block source and adder-tree model.
module tb_adder_tree_sched;
  localparam int unsigned D  = 12;
  localparam int unsigned IW = 16;

  typedef struct {
    int nb;
    int stall;
    int restart_at;
    int max0;
    int max1;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  logic start, in_valid, out_ready;
  logic [IW-1:0] num_blocks;
  logic [1151:0] in_data_v [2];
  logic [191:0]  at_sum_v [2];
  logic busy_v [2], done_v [2], in_ready_v [2], at_issue_v [2], out_valid_v [2];
  logic [1151:0] at_data_v [2];
  logic [191:0]  out_data_v [2];
  logic [IW-1:0] out_idx_v [2];

  always #5 clk = ~clk;

  adder_tree_sched_if #(.IDX_W(IW)) bus0 ();
  adder_tree_sched_if #(.IDX_W(IW)) bus1 ();

  adder_tree_sched #(.DELAY_ADD(D), .FIFO_DEPTH(16), .IDX_W(IW)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  adder_tree_sched #(.DELAY_ADD(D), .FIFO_DEPTH(4), .IDX_W(IW)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  assign bus0.start = start;        assign bus1.start = start;
  assign bus0.num_blocks = num_blocks; assign bus1.num_blocks = num_blocks;
  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
  assign bus0.in_data = in_data_v[0]; assign bus1.in_data = in_data_v[1];
  assign bus0.at_sum = at_sum_v[0];   assign bus1.at_sum = at_sum_v[1];
  assign busy_v[0] = bus0.busy;           assign busy_v[1] = bus1.busy;
  assign done_v[0] = bus0.done;           assign done_v[1] = bus1.done;
  assign in_ready_v[0] = bus0.in_ready;   assign in_ready_v[1] = bus1.in_ready;
  assign at_issue_v[0] = bus0.at_issue;   assign at_issue_v[1] = bus1.at_issue;
  assign at_data_v[0] = bus0.at_data;     assign at_data_v[1] = bus1.at_data;
  assign out_valid_v[0] = bus0.out_valid; assign out_valid_v[1] = bus1.out_valid;
  assign out_data_v[0] = bus0.out_data;   assign out_data_v[1] = bus1.out_data;
  assign out_idx_v[0] = bus0.out_idx;     assign out_idx_v[1] = bus1.out_idx;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc;
  int fd [2];
  int n_iss [2], n_pop [2], max_out [2], credit_viol [2], done_cnt [2], done_cyc [2];
  int first_iss [2], last_iss [2], first_ov [2];
  logic busy_seen [2];
  logic pipe_v [2][D];
  logic [191:0] pipe_s [2][D];
  logic cap_v [2];
  logic [191:0] cap_s [2];
  job_t jobs [5];

  // Block k: six 192-bit words built from k so every block is distinct.
  function automatic logic [1151:0] blk(input int k);
    logic [1151:0] b;
    for (int j = 0; j < 6; j++)
      b[j*192 +: 192] = {64'(k * 131 + j + 1), 64'h5A5A_0F0F_0000_0000 | 64'(j), 64'(k)};
    return b;
  endfunction

  // Adder-tree reference: sum of the six words modulo 2^192.
  function automatic logic [191:0] tsum(input logic [1151:0] b);
    logic [191:0] s;
    s = '0;
    for (int j = 0; j < 6; j++) s = s + b[j*192 +: 192];
    return s;
  endfunction

  task automatic chk(input string name, input int d, input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  // One clock: sample at negedge, advance the adder-tree models at posedge.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int outst;
      outst = n_iss[d] - n_pop[d];
      if (outst > max_out[d]) max_out[d] = outst;
      if (outst > fd[d] || (outst == fd[d] && in_ready_v[d] === 1'b1)) credit_viol[d]++;
      if (busy_v[d] === 1'b1) busy_seen[d] = 1'b1;
      if (done_v[d] === 1'b1) begin done_cnt[d]++; done_cyc[d] = cyc; end
      cap_v[d] = (at_issue_v[d] === 1'b1);
      cap_s[d] = tsum(at_data_v[d]);
      if (at_issue_v[d] === 1'b1) begin
        if (n_iss[d] == 0) first_iss[d] = cyc;
        last_iss[d] = cyc;
        n_iss[d]++;
      end
      if (out_valid_v[d] === 1'b1 && first_ov[d] < 0) first_ov[d] = cyc;
      if (out_valid_v[d] === 1'b1 && out_ready) begin
        chk("pop_idx_data", d, {out_idx_v[d], out_data_v[d]},
            {IW'(n_pop[d]), tsum(blk(n_pop[d]))});
        n_pop[d]++;
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int s = D - 1; s > 0; s--) begin
        pipe_v[d][s] = pipe_v[d][s-1];
        pipe_s[d][s] = pipe_s[d][s-1];
      end
      pipe_v[d][0] = cap_v[d];
      pipe_s[d][0] = cap_s[d];
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      in_data_v[d] = blk(n_iss[d]);
      at_sum_v[d]  = pipe_v[d][D-1] ? pipe_s[d][D-1] : {6{32'hDEADBEEF}};
    end
  endtask

  task automatic reset_job();
    for (int d = 0; d < 2; d++) begin
      n_iss[d] = 0; n_pop[d] = 0; max_out[d] = 0; credit_viol[d] = 0;
      done_cnt[d] = 0; done_cyc[d] = -1; first_iss[d] = -1; last_iss[d] = -1;
      first_ov[d] = -1; busy_seen[d] = 1'b0;
      in_data_v[d] = blk(0);
    end
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++)
      chk("reset_outputs", d,
          {busy_v[d], done_v[d], in_ready_v[d], at_issue_v[d], out_valid_v[d],
           out_idx_v[d], out_data_v[d]}, '0);
  endtask

  task automatic run_job(input job_t j, input int jn);
    int k;
    logic finished;
    reset_job();
    start = 1'b1;
    num_blocks = IW'(j.nb);
    out_ready = (j.stall == 0);
    step();
    start_cyc = cyc;
    start = 1'b0;
    k = 0;
    finished = 1'b0;
    while (!finished && k < 600) begin
      if (k == j.restart_at) begin start = 1'b1; num_blocks = 3; end
      else start = 1'b0;
      if (j.stall > 0 && k == j.stall) begin
        for (int d = 0; d < 2; d++) begin
          chk("stall_buffered", d, n_iss[d], fd[d]);
          chk("stall_in_ready", d, in_ready_v[d], 1'b0);
          chk("stall_out_valid", d, out_valid_v[d], 1'b1);
        end
        out_ready = 1'b1;
      end
      step();
      k++;
      if (done_cnt[0] > 0 && done_cnt[1] > 0) finished = 1'b1;
    end
    start = 1'b0;
    chk($sformatf("job%0d_completes", jn), 0, finished, 1'b1);
    repeat (5) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("job%0d_results", jn), d, n_pop[d], j.nb);
      chk($sformatf("job%0d_issues", jn), d, n_iss[d], j.nb);
      chk($sformatf("job%0d_done_once", jn), d, done_cnt[d], 1);
      chk($sformatf("job%0d_idle_after", jn), d, busy_v[d], 1'b0);
      chk($sformatf("job%0d_max_inflight", jn), d, max_out[d], (d == 0) ? j.max0 : j.max1);
      chk($sformatf("job%0d_credit_rule", jn), d, credit_viol[d], 0);
    end
    if (j.nb == 0) begin
      for (int d = 0; d < 2; d++) begin
        chk("zero_done_latency", d, done_cyc[d] - start_cyc, 1);
        chk("zero_never_busy", d, busy_seen[d], 1'b0);
      end
    end
  endtask

  initial begin
    int k;
    int stale;
    job_t tail;
    fd[0] = 16;
    fd[1] = 4;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < D; s++) begin pipe_v[d][s] = 1'b0; pipe_s[d][s] = '0; end
    reset_job();
    at_sum_v[0] = '0; at_sum_v[1] = '0;
    rst = 1'b1; start = 1'b0; num_blocks = '0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;

    jobs[0] = '{nb: 5,  stall: 0,   restart_at: -1, max0: 5,  max1: 4};
    jobs[1] = '{nb: 10, stall: 0,   restart_at: -1, max0: 10, max1: 4};
    jobs[2] = '{nb: 20, stall: 100, restart_at: -1, max0: 16, max1: 4};
    jobs[3] = '{nb: 0,  stall: 0,   restart_at: -1, max0: 0,  max1: 0};
    jobs[4] = '{nb: 7,  stall: 0,   restart_at: 3,  max0: 7,  max1: 4};
    for (int j = 0; j < 5; j++) begin
      run_job(jobs[j], j);
      if (j == 0) begin
        chk("first_result_latency", 0, first_ov[0] - first_iss[0], D + 1);
        chk("back_to_back_issue", 0, last_iss[0] - first_iss[0], 4);
      end
    end

    // Reset in the middle of an 8-block job.
    reset_job();
    start = 1'b1; num_blocks = 8; out_ready = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (n_iss[0] < 4 && k < 50) begin step(); k++; end
    chk("mid_job_four_issued", 0, n_iss[0], 4);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs();
    reset_job();
    stale = 0;
    repeat (30) begin
      step();
      for (int d = 0; d < 2; d++)
        if (out_valid_v[d] !== 1'b0 || done_v[d] !== 1'b0 || busy_v[d] !== 1'b0) stale++;
    end
    chk("no_stale_after_reset", 0, stale, 0);
    tail = '{nb: 2, stall: 0, restart_at: -1, max0: 2, max1: 2};
    run_job(tail, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
